// File: rtl/sha1_block_seq.sv
// rtl/sha1_block_seq.sv - multi-block sequencer around a combinational SHA-1 compression core (option: SHA1_BLOCK_SEQ_ABORT_EN adds abort_i)
module sha1_block_seq #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [511:0]     in_block_i,
  input  logic             in_last_i,
  output logic [511:0]     core_block_o,
  output logic [159:0]     core_prev_o,
  input  logic [159:0]     core_next_i,
  output logic             dig_valid_o,
  input  logic             dig_ready_i,
  output logic [159:0]     digest_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
`ifdef SHA1_BLOCK_SEQ_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  // SHA-1 initial chaining value {H0,H1,H2,H3,H4}
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  // Counter preload: completion happens WAIT_CYCLES edges after acceptance
  localparam logic [3:0]   WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e           state_q;
  logic [511:0]     blk_q;
  logic             last_q;
  logic [3:0]       wait_q;
  logic [159:0]     h_q;
  logic [159:0]     digest_q;
  logic             dig_valid_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_cnt_d;
  logic             abort_w;

`ifdef SHA1_BLOCK_SEQ_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign core_block_o = blk_q;
  assign core_prev_o  = h_q;
  assign in_ready_o   = (state_q == ST_IDLE) && rst_ni;
  assign dig_valid_o  = dig_valid_q;
  assign digest_o     = digest_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign blk_cnt_o    = blk_cnt_q;

  // Saturating block-count increment used when a compression completes
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (blk_cnt_q != {CNT_W{1'b1}}) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  // Sequencer FSM: accept block, wait for core to settle, fold result or emit digest
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      last_q      <= 1'b0;
      wait_q      <= '0;
      h_q         <= IV;
      digest_q    <= '0;
      dig_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (abort_w) begin
            h_q       <= IV;
            blk_cnt_q <= '0;
          end else if (in_valid_i) begin
            blk_q   <= in_block_i;
            last_q  <= in_last_i;
            wait_q  <= WAIT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort_w) begin
            h_q       <= IV;
            blk_cnt_q <= '0;
            wait_q    <= '0;
            state_q   <= ST_IDLE;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            blk_cnt_q <= blk_cnt_d;
            if (last_q) begin
              // Message finished: publish digest and rearm chaining state for the next message
              digest_q    <= core_next_i;
              dig_valid_q <= 1'b1;
              h_q         <= IV;
              state_q     <= ST_OUT;
            end else begin
              h_q     <= core_next_i;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_OUT: begin
          if (dig_ready_i) begin
            dig_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_seq.sv
// tb/tb_sha1_block_seq.sv - directed bench for sha1_block_seq with a behavioural SHA-1 core beside it
module tb_sha1_block_seq;

  localparam int W     = 2;
  localparam int CNT_W = 16;

  localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  logic             clk;
  logic             rst_ni;
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     in_block;
  logic             in_last;
  logic [511:0]     core_block;
  logic [159:0]     core_prev;
  logic [159:0]     core_next;
  logic             dig_valid;
  logic             dig_ready;
  logic [159:0]     digest;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;
`ifdef SHA1_BLOCK_SEQ_ABORT_EN
  logic             abort;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sha1_block_seq #(.WAIT_CYCLES(W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_block_i   (in_block),
    .in_last_i    (in_last),
    .core_block_o (core_block),
    .core_prev_o  (core_prev),
    .core_next_i  (core_next),
    .dig_valid_o  (dig_valid),
    .dig_ready_i  (dig_ready),
    .digest_o     (digest),
    .busy_o       (busy),
    .blk_cnt_o    (blk_cnt)
`ifdef SHA1_BLOCK_SEQ_ABORT_EN
    ,
    .abort_i      (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference SHA-1 compression function standing in for the external sha1_block core
  function automatic logic [159:0] sha1_f(input logic [159:0] h, input logic [511:0] b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h[159:128]; bb = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);           k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                     k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ d;                     k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  always_comb core_next = sha1_f(core_prev, core_block);

  // Presents a block from a negedge, returns at the negedge after the accepting edge
  task automatic send_block(input logic [511:0] blk, input logic last,
                            output int acc, output int lows);
    bit ok;
    ok = 0; lows = 0; acc = 0;
    in_block = blk; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1; break; end
      lows++;
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_timeout: in_ready_o never high in 50 cycles (required 1)"); end
  endtask

  task automatic wait_digest(output int dv);
    bit ok;
    ok = 0; dv = 0;
    for (int i = 0; i < 50; i++) begin
      if (dig_valid) begin ok = 1; dv = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL digest_timeout: dig_valid_o never high in 50 cycles (required 1)"); end
  endtask

  task automatic handshake;
    dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dig_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (dig_valid !== 1'b0) begin failures++; $display("FAIL rst_dig_valid: got %b need 0", dig_valid); end
    checks++; if (digest !== 160'h0) begin failures++; $display("FAIL rst_digest: got %h need 0", digest); end
    checks++; if (blk_cnt !== 16'h0) begin failures++; $display("FAIL rst_blk_cnt: got %0d need 0", blk_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b need 0", busy); end
    checks++; if (core_prev !== IV) begin failures++; $display("FAIL rst_core_prev: got %h need %h", core_prev, IV); end
    checks++; if (core_block !== 512'h0) begin failures++; $display("FAIL rst_core_block: got %h need 0", core_block); end
    rst_ni = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b need 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_abc;
    int acc, lows, dv;
    send_block(B_ABC, 1'b1, acc, lows);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL abc_wait_flags: busy=%b ready=%b need 1/0", busy, in_ready); end
    wait_digest(dv);
    checks++; if (dv - acc !== W) begin failures++; $display("FAIL abc_latency: got %0d need %0d", dv - acc, W); end
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL abc_digest: got %h need %h", digest, D_ABC); end
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("FAIL abc_blk_cnt: got %0d need 1", blk_cnt); end
    checks++; if (core_prev !== IV) begin failures++; $display("FAIL abc_h_rearm: got %h need %h", core_prev, IV); end
    handshake();
    checks++; if (dig_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abc_after_hs: valid=%b ready=%b busy=%b need 0/1/0", dig_valid, in_ready, busy); end
    checks++; if (blk_cnt !== 16'd0) begin failures++; $display("FAIL abc_cnt_clear: got %0d need 0", blk_cnt); end
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL abc_digest_hold: got %h need %h", digest, D_ABC); end
  endtask

  task automatic test_empty_then_abc;
    int acc, lows, dv;
    dig_ready = 1'b1;
    send_block(B_EMPTY, 1'b1, acc, lows);
    wait_digest(dv);
    checks++; if (digest !== D_EMPTY) begin failures++; $display("FAIL empty_digest: got %h need %h", digest, D_EMPTY); end
    checks++; if (dv - acc !== W) begin failures++; $display("FAIL empty_latency: got %0d need %0d", dv - acc, W); end
    @(negedge clk);
    checks++; if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL empty_hs: valid=%b ready=%b need 0/1", dig_valid, in_ready); end
    send_block(B_ABC, 1'b1, acc, lows);
    wait_digest(dv);
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL b2b_abc_digest: got %h need %h", digest, D_ABC); end
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("FAIL b2b_abc_cnt: got %0d need 1", blk_cnt); end
    @(negedge clk);
    dig_ready = 1'b0;
  endtask

  task automatic test_two_block;
    int acc1, acc2, lows, dv;
    send_block(B_TWO1, 1'b0, acc1, lows);
    send_block(B_TWO2, 1'b1, acc2, lows);
    checks++; if (acc2 - acc1 !== W + 1) begin failures++; $display("FAIL two_interval: got %0d need %0d", acc2 - acc1, W + 1); end
    checks++; if (lows !== W) begin failures++; $display("FAIL two_ready_low: got %0d need %0d", lows, W); end
    checks++; if (core_prev !== sha1_f(IV, B_TWO1)) begin failures++; $display("FAIL two_chain: got %h need %h", core_prev, sha1_f(IV, B_TWO1)); end
    wait_digest(dv);
    checks++; if (digest !== D_TWO) begin failures++; $display("FAIL two_digest: got %h need %h", digest, D_TWO); end
    checks++; if (blk_cnt !== 16'd2) begin failures++; $display("FAIL two_blk_cnt: got %0d need 2", blk_cnt); end
    handshake();
  endtask

  task automatic test_backpressure;
    int acc, lows, dv, bad_v, bad_d, bad_r;
    bad_v = 0; bad_d = 0; bad_r = 0;
    send_block(B_ABC, 1'b1, acc, lows);
    wait_digest(dv);
    in_block = B_EMPTY; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dig_valid !== 1'b1) bad_v++;
      if (digest !== D_ABC) bad_d++;
      if (in_ready !== 1'b0) bad_r++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (bad_v != 0) begin failures++; $display("FAIL bp_valid_stable: %0d cycles dropped, need 0", bad_v); end
    checks++; if (bad_d != 0) begin failures++; $display("FAIL bp_digest_stable: %0d cycles changed, need 0", bad_d); end
    checks++; if (bad_r != 0) begin failures++; $display("FAIL bp_ready_low: %0d cycles ready high, need 0", bad_r); end
    handshake();
    checks++; if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: valid=%b ready=%b need 0/1", dig_valid, in_ready); end
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL bp_digest_hold: got %h need %h", digest, D_ABC); end
  endtask

  task automatic test_reset_mid;
    int acc, lows, dv;
    send_block(B_TWO1, 1'b0, acc, lows);
    rst_ni = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    checks++; if (busy !== 1'b0 || blk_cnt !== 16'd0 || dig_valid !== 1'b0) begin failures++; $display("FAIL rmid_state: busy=%b cnt=%0d valid=%b need 0/0/0", busy, blk_cnt, dig_valid); end
    checks++; if (core_prev !== IV) begin failures++; $display("FAIL rmid_h: got %h need %h", core_prev, IV); end
    repeat (W + 2) @(negedge clk);
    checks++; if (core_prev !== IV || blk_cnt !== 16'd0) begin failures++; $display("FAIL rmid_no_update: h=%h cnt=%0d need IV/0", core_prev, blk_cnt); end
    send_block(B_ABC, 1'b1, acc, lows);
    wait_digest(dv);
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL rmid_abc_digest: got %h need %h", digest, D_ABC); end
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("FAIL rmid_abc_cnt: got %0d need 1", blk_cnt); end
    handshake();
  endtask

`ifdef SHA1_BLOCK_SEQ_ABORT_EN
  task automatic test_abort;
    int acc, lows, dv;
    send_block(B_TWO1, 1'b0, acc, lows);
    repeat (W) @(negedge clk);
    checks++; if (blk_cnt !== 16'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL abort_pre: cnt=%0d ready=%b need 1/1", blk_cnt, in_ready); end
    abort = 1'b1;
    in_block = B_TWO2; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_priority: busy=%b need 0", busy); end
    checks++; if (core_prev !== IV || blk_cnt !== 16'd0) begin failures++; $display("FAIL abort_clear: h=%h cnt=%0d need IV/0", core_prev, blk_cnt); end
    send_block(B_ABC, 1'b1, acc, lows);
    wait_digest(dv);
    checks++; if (digest !== D_ABC) begin failures++; $display("FAIL abort_abc_digest: got %h need %h", digest, D_ABC); end
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("FAIL abort_abc_cnt: got %0d need 1", blk_cnt); end
    handshake();
  endtask
`endif

  initial begin
    rst_ni = 1'b0; in_valid = 1'b0; in_block = '0; in_last = 1'b0; dig_ready = 1'b0;
`ifdef SHA1_BLOCK_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single_abc();
    test_empty_then_abc();
    test_two_block();
    test_backpressure();
    test_reset_mid();
`ifdef SHA1_BLOCK_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
